// File: rtl/clock_edit_ctrl.sv
// Front-panel button controller for the 24 h clock: debounced buttons feed a
// field-select FSM, increment pulses with auto-repeat, window offset, blink and idle exit.
module clock_edit_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned REPEAT_DLY   = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 5_000_000,
   parameter int unsigned BLINK_HALF   = 12_500_000,
   parameter int unsigned IDLE_TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bt,
   output logic [1:0] sel,
   output logic       inc_h,
   output logic       inc_m,
   output logic       inc_s,
   output logic [1:0] off,
   output logic       blink,
   output logic       run_en
);

   typedef enum logic [1:0] {
      SEL_RUN  = 2'd0,
      SEL_HOUR = 2'd1,
      SEL_MIN  = 2'd2,
      SEL_SEC  = 2'd3
   } sel_t;

   localparam logic [31:0] DB_LIMIT   = 32'(DEBOUNCE_CYC);
   localparam logic [31:0] DLY_LAST   = 32'(REPEAT_DLY - 1);
   localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
   localparam logic [31:0] IDLE_LAST  = 32'(IDLE_TIMEOUT - 1);

   logic [3:0] press;
   logic       inc_held;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         logic        sync1_reg, sync2_reg, stable_reg, stable_prev_reg;
         logic [31:0] db_cnt_reg;

         // The stable level only flips after the synced level has disagreed for DB_LIMIT+1 edges.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg       <= 1'b0;
               sync2_reg       <= 1'b0;
               stable_reg      <= 1'b0;
               stable_prev_reg <= 1'b0;
               db_cnt_reg      <= '0;
            end else begin
               sync1_reg       <= bt[gi];
               sync2_reg       <= sync1_reg;
               stable_prev_reg <= stable_reg;
               if (sync2_reg == stable_reg) begin
                  db_cnt_reg <= '0;
               end else if (db_cnt_reg == DB_LIMIT) begin
                  stable_reg <= sync2_reg;
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + 32'd1;
               end
            end
         end

         assign press[gi] = stable_reg & ~stable_prev_reg;
      end
   endgenerate

   assign inc_held = g_btn[2].stable_reg;

   sel_t        sel_reg, sel_next;
   logic [1:0]  off_reg, off_next;
   logic        inc_h_reg, inc_h_next, inc_m_reg, inc_m_next, inc_s_reg, inc_s_next;
   logic        blink_reg, blink_next, run_en_reg, run_en_next;
   logic [31:0] idle_cnt_reg, idle_cnt_next, blink_cnt_reg, blink_cnt_next;
   logic [31:0] rep_cnt_reg, rep_cnt_next;
   logic        rep_act_reg, rep_act_next, rep_dly_done_reg, rep_dly_done_next;
   logic        sel_chg, inc_fire, rep_due, idle_expired;

   always_comb begin
      sel_next          = sel_reg;
      off_next          = off_reg;
      inc_h_next        = 1'b0;
      inc_m_next        = 1'b0;
      inc_s_next        = 1'b0;
      inc_fire          = 1'b0;
      blink_next        = blink_reg;
      blink_cnt_next    = blink_cnt_reg;
      idle_cnt_next     = idle_cnt_reg;
      rep_act_next      = rep_act_reg;
      rep_cnt_next      = rep_cnt_reg;
      rep_dly_done_next = rep_dly_done_reg;

      rep_due = rep_act_reg && inc_held &&
                (rep_cnt_reg == (rep_dly_done_reg ? RATE_LAST : DLY_LAST));
      // A press in the same cycle as the timeout keeps the user in the edit state.
      idle_expired = (sel_reg != SEL_RUN) && !(|press) && (idle_cnt_reg == IDLE_LAST);

      if (press[0] && !press[1]) begin
         off_next = (off_reg == 2'd2) ? 2'd2 : off_reg + 2'd1;
      end else if (press[1] && !press[0]) begin
         off_next = (off_reg == 2'd0) ? 2'd0 : off_reg - 2'd1;
      end

      if (press[3]) begin
         sel_next = sel_t'(sel_reg + 2'd1);
         if (sel_next == SEL_HOUR) begin
            off_next = 2'd0;
         end else if (sel_next == SEL_SEC) begin
            off_next = 2'd2;
         end
      end else if (idle_expired) begin
         sel_next = SEL_RUN;
      end else if (sel_reg != SEL_RUN && (press[2] || rep_due)) begin
         inc_fire   = 1'b1;
         inc_h_next = (sel_reg == SEL_HOUR);
         inc_m_next = (sel_reg == SEL_MIN);
         inc_s_next = (sel_reg == SEL_SEC);
      end

      sel_chg = (sel_next != sel_reg);

      if (sel_chg || !inc_held) begin
         rep_act_next      = 1'b0;
         rep_cnt_next      = '0;
         rep_dly_done_next = 1'b0;
      end else if (inc_fire) begin
         rep_act_next      = 1'b1;
         rep_cnt_next      = '0;
         rep_dly_done_next = !press[2];
      end else if (rep_act_reg) begin
         rep_cnt_next = rep_cnt_reg + 32'd1;
      end

      if (sel_next == SEL_RUN || sel_chg || (|press)) begin
         idle_cnt_next = '0;
      end else begin
         idle_cnt_next = idle_cnt_reg + 32'd1;
      end

      if (sel_next == SEL_RUN || sel_chg || inc_fire) begin
         blink_next     = 1'b1;
         blink_cnt_next = '0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
         blink_next     = !blink_reg;
         blink_cnt_next = '0;
      end else begin
         blink_cnt_next = blink_cnt_reg + 32'd1;
      end

      run_en_next = (sel_next != SEL_SEC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_reg          <= SEL_RUN;
         off_reg          <= 2'd0;
         inc_h_reg        <= 1'b0;
         inc_m_reg        <= 1'b0;
         inc_s_reg        <= 1'b0;
         blink_reg        <= 1'b1;
         run_en_reg       <= 1'b1;
         idle_cnt_reg     <= '0;
         blink_cnt_reg    <= '0;
         rep_cnt_reg      <= '0;
         rep_act_reg      <= 1'b0;
         rep_dly_done_reg <= 1'b0;
      end else begin
         sel_reg          <= sel_next;
         off_reg          <= off_next;
         inc_h_reg        <= inc_h_next;
         inc_m_reg        <= inc_m_next;
         inc_s_reg        <= inc_s_next;
         blink_reg        <= blink_next;
         run_en_reg       <= run_en_next;
         idle_cnt_reg     <= idle_cnt_next;
         blink_cnt_reg    <= blink_cnt_next;
         rep_cnt_reg      <= rep_cnt_next;
         rep_act_reg      <= rep_act_next;
         rep_dly_done_reg <= rep_dly_done_next;
      end
   end

   assign sel    = sel_reg;
   assign off    = off_reg;
   assign inc_h  = inc_h_reg;
   assign inc_m  = inc_m_reg;
   assign inc_s  = inc_s_reg;
   assign blink  = blink_reg;
   assign run_en = run_en_reg;

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// Directed and randomized bench for clock_edit_ctrl using small parameters and an
// event-level model of the panel (mode ring, window clamping, latency and repeat schedule).
module tb_clock_edit_ctrl;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RR = 5;
   localparam int BH = 8;
   localparam int TO = 100;
   localparam int LAT = D + 4;   // drive after edge c -> command visible after edge c+LAT

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bt;
   logic [1:0] sel, off;
   logic       inc_h, inc_m, inc_s, blink, run_en;

   clock_edit_ctrl #(
      .DEBOUNCE_CYC(D), .REPEAT_DLY(RD), .REPEAT_RATE(RR),
      .BLINK_HALF(BH), .IDLE_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .bt(bt), .sel(sel),
      .inc_h(inc_h), .inc_m(inc_m), .inc_s(inc_s),
      .off(off), .blink(blink), .run_en(run_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int cnt_h = 0, cnt_m = 0, cnt_s = 0, multi_hot = 0;
   int s_times[$];

   // reference model state
   int m_sel = 0, m_off = 0, m_h = 0, m_m = 0, m_s = 0;
   int last_cmd = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (inc_h) cnt_h++;
      if (inc_m) cnt_m++;
      if (inc_s) begin
         cnt_s++;
         s_times.push_back(cyc);
      end
      if (int'(inc_h) + int'(inc_m) + int'(inc_s) > 1) multi_hot++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1, "bench did not complete");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_mode();
      m_sel = (m_sel + 1) % 4;
      if (m_sel == 1) m_off = 0;
      if (m_sel == 3) m_off = 2;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_sel"}, int'(sel), m_sel);
      chk({tag, "_off"}, int'(off), m_off);
      chk({tag, "_run_en"}, int'(run_en), (m_sel != 3) ? 1 : 0);
   endtask

   // One clean press of button b, held long enough to debounce, then released.
   task automatic press(input int b, input string tag);
      int exp_inc;
      exp_inc = 0;
      bt[b] = 1'b1;
      step(LAT);
      last_cmd = cyc;
      case (b)
         0: m_off = (m_off < 2) ? m_off + 1 : 2;
         1: m_off = (m_off > 0) ? m_off - 1 : 0;
         2: if (m_sel != 0) begin
               exp_inc = 1 << (3 - m_sel);
               if (m_sel == 1) m_h++;
               if (m_sel == 2) m_m++;
               if (m_sel == 3) m_s++;
            end
         default: model_mode();
      endcase
      check_state(tag);
      chk({tag, "_inc"}, int'({inc_h, inc_m, inc_s}), exp_inc);
      if (exp_inc != 0) chk({tag, "_blink"}, int'(blink), 1);
      bt[b] = 1'b0;
      step(LAT);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_sel"}, int'(sel), 0);
      chk({tag, "_off"}, int'(off), 0);
      chk({tag, "_inc"}, int'({inc_h, inc_m, inc_s}), 0);
      chk({tag, "_blink"}, int'(blink), 1);
      chk({tag, "_run_en"}, int'(run_en), 1);
   endtask

   initial begin
      int t0, rel, k, n_exp, e;
      bt  = 4'b0000;
      rst = 1'b1;
      step(3);
      check_reset("reset");
      rst = 1'b0;
      step(2);

      // random window presses while running
      for (int i = 0; i < 4; i++) press(int'($urandom_range(0, 1)), "win_run");

      // bouncing MODE settles into a single step to HOUR
      for (int i = 0; i < 10; i++) begin
         bt[3] = ~bt[3];
         step(1);
      end
      chk("bounce_sel", int'(sel), 0);
      bt[3] = 1'b1;
      step(LAT);
      model_mode();
      check_state("bounce_hour");
      step(10);
      bt[3] = 1'b0;
      step(10);
      chk("bounce_once", int'(sel), 1);

      // window move in HOUR survives entry to MIN
      press(0, "win_hour");
      press(3, "to_min");

      // random INC presses in MIN, then one timed pulse
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) press(2, "inc_min");
      bt[2] = 1'b1;
      step(LAT - 1);
      chk("incm_early", int'({inc_h, inc_m, inc_s}), 0);
      step(1);
      m_m++;
      chk("incm_pulse", int'({inc_h, inc_m, inc_s}), 3'b010);
      chk("incm_blink", int'(blink), 1);
      step(1);
      chk("incm_single", int'({inc_h, inc_m, inc_s}), 0);
      bt[2] = 1'b0;
      step(LAT);

      // SEC: held INC gives first pulse, delay, then fixed-rate repeats until release
      press(3, "to_sec");
      s_times.delete();
      bt[2] = 1'b1;
      t0  = cyc + LAT;
      rel = cyc + 60 + LAT;
      step(60);
      chk("hold_run_en", int'(run_en), 0);
      bt[2] = 1'b0;
      step(12);
      chk("rel_run_en", int'(run_en), 0);
      n_exp = 0;
      for (int t = t0; t < rel; t += (t == t0) ? RD : RR) begin
         chk("rep_time", (n_exp < s_times.size()) ? s_times[n_exp] : -1, t);
         n_exp++;
         m_s++;
      end
      chk("rep_count", s_times.size(), n_exp);

      // window clamping and simultaneous left/right
      press(0, "win_sat");
      press(1, "win_l1");
      press(1, "win_l2");
      press(1, "win_l3");
      press(0, "win_r");
      bt[0] = 1'b1;
      bt[1] = 1'b1;
      step(LAT);
      chk("win_both", int'(off), m_off);
      bt[0] = 1'b0;
      bt[1] = 1'b0;
      step(LAT);

      // blink phase and idle timeout in HOUR
      press(3, "to_run");
      press(3, "to_hour");
      e = last_cmd;
      while (cyc < e + TO) begin
         k = cyc - e;
         if (k <= 40) chk("blink_phase", int'(blink), ((k / BH) % 2 == 0) ? 1 : 0);
         if (k == TO - 1) chk("idle_hold", int'(sel), 1);
         step(1);
      end
      m_sel = 0;
      check_state("idle_exit");
      chk("idle_blink", int'(blink), 1);

      // MODE and INC together: MODE wins
      press(3, "to_hour2");
      bt[3] = 1'b1;
      bt[2] = 1'b1;
      step(LAT);
      model_mode();
      check_state("mode_inc");
      chk("mode_inc_pulse", int'({inc_h, inc_m, inc_s}), 0);
      bt[3] = 1'b0;
      step(4);

      // reset while INC is still held; the press that follows lands in RUN
      rst = 1'b1;
      step(1);
      check_reset("mid_rst");
      rst = 1'b0;
      m_sel = 0;
      m_off = 0;
      step(LAT);
      check_state("post_rst");
      chk("post_rst_inc", int'({inc_h, inc_m, inc_s}), 0);
      step(20);
      bt[2] = 1'b0;
      step(10);

      chk("total_h", cnt_h, m_h);
      chk("total_m", cnt_m, m_m);
      chk("total_s", cnt_s, m_s);
      chk("one_hot", multi_hot, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
